// File: rtl/alu_operand_stage_if.sv
// Handshake and write-back bundle between the decoder, alu_operand_stage and the 8-bit ALU.
// The slave modport is the operand stage; master is whoever drives instructions and write-backs.
interface alu_operand_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [2:0] in_ra;
    logic [2:0] in_rb;
    logic [2:0] in_rd;
    logic       in_we;
    logic       in_use_imm;
    logic [7:0] in_imm;
    logic       in_sl;
    logic [2:0] in_simm;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_op;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       out_sl;
    logic [2:0] out_simm;
    logic [2:0] out_rd;
    logic       out_we;
    logic       wb_en;
    logic [2:0] wb_rd;
    logic [7:0] wb_r;
    logic       wb_flags_en;
    logic [3:0] wb_flags;
    logic [3:0] flags;

    modport slave (
        input  in_valid, in_op, in_ra, in_rb, in_rd, in_we, in_use_imm, in_imm, in_sl, in_simm,
        input  out_ready, wb_en, wb_rd, wb_r, wb_flags_en, wb_flags,
        output in_ready, out_valid, out_op, out_a, out_b, out_sl, out_simm, out_rd, out_we, flags
    );

    modport master (
        output in_valid, in_op, in_ra, in_rb, in_rd, in_we, in_use_imm, in_imm, in_sl, in_simm,
        output out_ready, wb_en, wb_rd, wb_r, wb_flags_en, wb_flags,
        input  in_ready, out_valid, out_op, out_a, out_b, out_sl, out_simm, out_rd, out_we, flags
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the 8-bit ALU: register file, flags, busy scoreboard, one-entry output buffer.
// Optional feature: define ALU_OPERAND_ZERO_REG_EN to hard-wire r0 to zero.
module alu_operand_stage (
    input  logic               clk,
    input  logic               reset,
    alu_operand_stage_if.slave bus
);
    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

    state_e     state_q;
    logic [7:0] regs_q [8];
    logic [7:0] busy_q;
    logic [7:0] busy_d;
    logic [3:0] flags_q;
    logic [2:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       sl_q;
    logic [2:0] simm_q;
    logic [2:0] rd_q;
    logic       we_q;

    logic [7:0] wb_clr_s;
    logic [7:0] set_s;
    logic [7:0] busy_eff_s;
    logic       hazard_s;
    logic       in_ready_s;
    logic       accept_s;
    logic [7:0] opnd_a_s;
    logic [7:0] opnd_b_s;

    // Same-cycle write-back wins over the stored value, so a stalled consumer can issue the cycle its producer retires.
    function automatic logic [7:0] read_operand(input logic [2:0] idx, input logic [7:0] rf_val,
                                                input logic wb_en, input logic [2:0] wb_rd,
                                                input logic [7:0] wb_r);
        logic [7:0] val;
        if (wb_en && (wb_rd == idx)) val = wb_r;
        else                         val = rf_val;
`ifdef ALU_OPERAND_ZERO_REG_EN
        if (idx == 3'd0) val = 8'h00;
        else             val = val;
`endif
        return val;
    endfunction

    // Hazard detection, handshake and scoreboard next-state.
    always_comb begin
        wb_clr_s = 8'h00;
        set_s    = 8'h00;
        if (bus.wb_en) wb_clr_s[bus.wb_rd] = 1'b1;
        else           wb_clr_s = 8'h00;
        busy_eff_s = busy_q & ~wb_clr_s;
        hazard_s   = busy_eff_s[bus.in_ra] | (~bus.in_use_imm & busy_eff_s[bus.in_rb]);
        in_ready_s = ((state_q == ST_EMPTY) | bus.out_ready) & ~hazard_s;
        accept_s   = bus.in_valid & in_ready_s;
        if (accept_s && bus.in_we) set_s[bus.in_rd] = 1'b1;
        else                       set_s = 8'h00;
`ifdef ALU_OPERAND_ZERO_REG_EN
        set_s[0] = 1'b0;
`endif
        busy_d   = busy_eff_s | set_s;
        opnd_a_s = read_operand(bus.in_ra, regs_q[bus.in_ra], bus.wb_en, bus.wb_rd, bus.wb_r);
        if (bus.in_use_imm) opnd_b_s = bus.in_imm;
        else                opnd_b_s = read_operand(bus.in_rb, regs_q[bus.in_rb], bus.wb_en, bus.wb_rd, bus.wb_r);
    end

    // Register file, flags and scoreboard state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
            flags_q <= 4'h0;
            busy_q  <= 8'h00;
        end else begin
`ifdef ALU_OPERAND_ZERO_REG_EN
            if (bus.wb_en && (bus.wb_rd != 3'd0)) regs_q[bus.wb_rd] <= bus.wb_r;
`else
            if (bus.wb_en) regs_q[bus.wb_rd] <= bus.wb_r;
`endif
            if (bus.wb_flags_en) flags_q <= bus.wb_flags;
            busy_q <= busy_d;
        end
    end

    // Output buffer FSM; the bundle is only loaded on accept, so it stays frozen while FULL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            op_q    <= 3'd0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            sl_q    <= 1'b0;
            simm_q  <= 3'd0;
            rd_q    <= 3'd0;
            we_q    <= 1'b0;
        end else begin
            if (accept_s) begin
                op_q   <= bus.in_op;
                a_q    <= opnd_a_s;
                b_q    <= opnd_b_s;
                sl_q   <= bus.in_sl;
                simm_q <= bus.in_simm;
                rd_q   <= bus.in_rd;
                we_q   <= bus.in_we;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) state_q <= ST_FULL;
                    else          state_q <= ST_EMPTY;
                end
                ST_FULL: begin
                    if (!accept_s && bus.out_ready) state_q <= ST_EMPTY;
                    else                            state_q <= ST_FULL;
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_op    = op_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_sl    = sl_q;
    assign bus.out_simm  = simm_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_we    = we_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed test-plan sequences followed by randomized traffic.
module tb_alu_operand_stage;
    logic clk;
    logic reset;
    alu_operand_stage_if bus ();

    alu_operand_stage dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       sl;
        logic [2:0] simm;
        logic [2:0] rd;
        logic       we;
    } bundle_t;

    bundle_t    exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] m_regs [8];
    logic       m_busy [8];
    logic [3:0] m_flags;
    logic       m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit zero_reg(input logic [2:0] idx);
`ifdef ALU_OPERAND_ZERO_REG_EN
        return idx == 3'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] model_read(input logic [2:0] idx);
        if (zero_reg(idx)) return 8'h00;
        if (bus.wb_en && bus.wb_rd == idx) return bus.wb_r;
        return m_regs[idx];
    endfunction

    function automatic bit model_busy(input logic [2:0] idx);
        return m_busy[idx] && !(bus.wb_en && bus.wb_rd == idx);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 8'h00;
            m_busy[i] = 1'b0;
        end
        m_flags = 4'h0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_ra = 3'd0; bus.in_rb = 3'd0;
        bus.in_rd = 3'd0; bus.in_we = 1'b0; bus.in_use_imm = 1'b0; bus.in_imm = 8'h00;
        bus.in_sl = 1'b0; bus.in_simm = 3'd0; bus.out_ready = 1'b1;
        bus.wb_en = 1'b0; bus.wb_rd = 3'd0; bus.wb_r = 8'h00;
        bus.wb_flags_en = 1'b0; bus.wb_flags = 4'h0;
    endtask

    // Called just after a rising edge with inputs already driven; predicts, checks, then advances one cycle.
    task automatic step();
        bit      hazard, exp_ready, accept;
        bundle_t e;
        #1;
        hazard    = model_busy(bus.in_ra) || (!bus.in_use_imm && model_busy(bus.in_rb));
        exp_ready = (!m_valid || bus.out_ready) && !hazard;
        accept    = bus.in_valid && exp_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("flags", 32'(bus.flags), 32'(m_flags));
        if (accept) begin
            e.op = bus.in_op; e.a = model_read(bus.in_ra);
            e.b = bus.in_use_imm ? bus.in_imm : model_read(bus.in_rb);
            e.sl = bus.in_sl; e.simm = bus.in_simm; e.rd = bus.in_rd; e.we = bus.in_we;
            exp_q.push_back(e);
        end
        if (bus.wb_en) begin
            m_busy[bus.wb_rd] = 1'b0;
            if (!zero_reg(bus.wb_rd)) m_regs[bus.wb_rd] = bus.wb_r;
        end
        if (accept && bus.in_we && !zero_reg(bus.in_rd)) m_busy[bus.in_rd] = 1'b1;
        if (bus.wb_flags_en) m_flags = bus.wb_flags;
        if (accept) m_valid = 1'b1;
        else if (bus.out_ready) m_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a bundle seen valid with out_ready high mid-cycle is consumed at the coming edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bundle", 32'(1), 32'(0));
            end else begin
                bundle_t e;
                bundle_t a;
                e = exp_q.pop_front();
                a = {bus.out_op, bus.out_a, bus.out_b, bus.out_sl, bus.out_simm, bus.out_rd, bus.out_we};
                chk("bundle", 32'(a), 32'(e));
            end
        end
    end

    initial begin
        idle();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_flags", 32'(bus.flags), 32'(0));
        chk("rst_out_ab", 32'({bus.out_a, bus.out_b}), 32'(0));
        chk("rst_out_misc", 32'({bus.out_op, bus.out_sl, bus.out_simm, bus.out_rd, bus.out_we}), 32'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Write r3 then read it through both sources.
        bus.wb_en = 1'b1; bus.wb_rd = 3'd3; bus.wb_r = 8'h5A; step();
        idle(); bus.in_valid = 1'b1; bus.in_ra = 3'd3; bus.in_rb = 3'd3; step();
        idle(); bus.in_valid = 1'b1; bus.in_op = 3'd2; bus.in_ra = 3'd1; bus.in_use_imm = 1'b1;
        bus.in_imm = 8'h81; bus.in_sl = 1'b1; bus.in_simm = 3'd5; step();
        // Back-pressure while FULL, then release.
        idle(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_op = 3'd6; bus.in_ra = 3'd5; bus.in_rb = 3'd6;
        step(); step();
        bus.out_ready = 1'b1; step();
        // RAW hazard on r4 resolved through the bypass.
        idle(); bus.in_valid = 1'b1; bus.in_rd = 3'd4; bus.in_we = 1'b1; step();
        idle(); bus.in_valid = 1'b1; bus.in_ra = 3'd4; step(); step();
        bus.wb_en = 1'b1; bus.wb_rd = 3'd4; bus.wb_r = 8'h33; step();
        // Set and clear of r2 in the same cycle: set wins.
        idle(); bus.in_valid = 1'b1; bus.in_rd = 3'd2; bus.in_we = 1'b1; bus.wb_en = 1'b1; bus.wb_rd = 3'd2;
        bus.wb_r = 8'h44; step();
        idle(); bus.in_valid = 1'b1; bus.in_ra = 3'd2; step();
        idle(); bus.wb_en = 1'b1; bus.wb_rd = 3'd2; bus.wb_r = 8'h99; bus.wb_flags_en = 1'b1; bus.wb_flags = 4'hA; step();
        // r0 write then read.
        idle(); bus.wb_en = 1'b1; bus.wb_rd = 3'd0; bus.wb_r = 8'hFF; step();
        idle(); bus.in_valid = 1'b1; bus.in_ra = 3'd0; bus.in_rb = 3'd0; step();
        idle(); step();

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b1;
                #1;
                chk("midrun_rst_out_valid", 32'(bus.out_valid), 32'(0));
                chk("midrun_rst_flags", 32'(bus.flags), 32'(0));
                model_reset();
                @(posedge clk); #1;
                reset = 1'b0;
            end
            bus.in_valid    = ($urandom % 10) < 7;
            bus.in_op       = 3'($urandom);
            bus.in_ra       = 3'($urandom);
            bus.in_rb       = 3'($urandom);
            bus.in_rd       = 3'($urandom);
            bus.in_we       = ($urandom % 10) < 6;
            bus.in_use_imm  = ($urandom % 4) == 0;
            bus.in_imm      = 8'($urandom);
            bus.in_sl       = 1'($urandom);
            bus.in_simm     = 3'($urandom);
            bus.out_ready   = ($urandom % 10) < 7;
            bus.wb_en       = ($urandom % 10) < 4;
            bus.wb_rd       = 3'($urandom);
            bus.wb_r        = 8'($urandom);
            bus.wb_flags_en = ($urandom % 4) == 0;
            bus.wb_flags    = 4'($urandom);
            step();
        end

        idle();
        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
